// File: rtl/vga_rect_fill_if.sv
// Frame-buffer port A write channel driven by the rectangle fill engine.
interface vga_rect_fill_if;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic        FB_WE;

    modport master (output FB_ADDR, FB_DATA, FB_WE);
    modport slave  (input  FB_ADDR, FB_DATA, FB_WE);
endinterface

// File: rtl/vga_rect_fill.sv
// Bus-programmed rectangle fill engine: clips two corners to the frame and
// streams one frame-buffer write per cycle in raster order.
module vga_rect_fill #(
    parameter logic [7:0]  BaseAddr = 8'hB8,
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_PIXELS = 120
) (
    input  logic            CLK,
    input  logic            RESET,
    inout  wire  [7:0]      BUS_DATA,
    input  logic [7:0]      BUS_ADDR,
    input  logic            BUS_WE,
    vga_rect_fill_if.master fb,
    output logic            BUSY,
    output logic            DONE_IRQ
);
    localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
    localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        FILL   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  x0_r, y0_r, x1_r, y1_r;
    logic        pix_r, done_r;
    logic [7:0]  wx0_r, wy0_r, wx1_r, wy1_r;
    logic        wpix_r;
    logic [7:0]  xmin_r, xmax_r, ymax_r;
    logic [7:0]  x_r, y_r, nx_s, ny_s;
    logic [7:0]  lo_x_s, hi_x_s, lo_y_s, hi_y_s, max_x_s, max_y_s;
    logic [14:0] fb_addr_r;
    logic        fb_data_r, fb_we_r, busy_r, irq_r;
    logic [7:0]  rd_data_r, rd_mux_s, off8_s;
    logic        rd_oe_r;
    logic [2:0]  offset_s;
    logic        in_range_s, wr_s, rd_s, start_s;

    assign off8_s     = BUS_ADDR - BaseAddr;
    assign in_range_s = (BUS_ADDR >= BaseAddr) && (off8_s <= 8'd5);
    assign offset_s   = off8_s[2:0];
    assign wr_s       = in_range_s && BUS_WE;
    assign rd_s       = in_range_s && !BUS_WE;
    assign start_s    = wr_s && (offset_s == 3'd4) && BUS_DATA[1] && (state_r == IDLE);

    // Corners may arrive in either order; clip the far edge, never wrap.
    assign lo_x_s  = (wx0_r < wx1_r) ? wx0_r : wx1_r;
    assign max_x_s = (wx0_r < wx1_r) ? wx1_r : wx0_r;
    assign hi_x_s  = (max_x_s > X_LAST) ? X_LAST : max_x_s;
    assign lo_y_s  = (wy0_r < wy1_r) ? wy0_r : wy1_r;
    assign max_y_s = (wy0_r < wy1_r) ? wy1_r : wy0_r;
    assign hi_y_s  = (max_y_s > Y_LAST) ? Y_LAST : max_y_s;

    // Next state and next pixel; x_r/y_r hold the pixel currently on the port.
    always_comb begin
        state_s = state_r;
        nx_s    = x_r;
        ny_s    = y_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = SETUP;
                else         state_s = IDLE;
            end
            SETUP: begin
                if ((lo_x_s > X_LAST) || (lo_y_s > Y_LAST)) begin
                    state_s = FINISH;
                end else begin
                    state_s = FILL;
                    nx_s    = lo_x_s;
                    ny_s    = lo_y_s;
                end
            end
            FILL: begin
                if ((x_r == xmax_r) && (y_r == ymax_r)) begin
                    state_s = FINISH;
                end else if (x_r == xmax_r) begin
                    nx_s = xmin_r;
                    ny_s = y_r + 8'd1;
                end else begin
                    nx_s = x_r + 8'd1;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux_s = 8'h00;
        case (offset_s)
            3'd0:    rd_mux_s = x0_r;
            3'd1:    rd_mux_s = y0_r;
            3'd2:    rd_mux_s = x1_r;
            3'd3:    rd_mux_s = y1_r;
            3'd4:    rd_mux_s = {7'd0, pix_r};
            3'd5:    rd_mux_s = {6'd0, done_r, busy_r};
            default: rd_mux_s = 8'h00;
        endcase
    end

    // Bus-visible registers and the sticky DONE flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0_r   <= 8'd0;
            y0_r   <= 8'd0;
            x1_r   <= 8'd0;
            y1_r   <= 8'd0;
            pix_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (wr_s) begin
                case (offset_s)
                    3'd0:    x0_r  <= BUS_DATA;
                    3'd1:    y0_r  <= BUS_DATA;
                    3'd2:    x1_r  <= BUS_DATA;
                    3'd3:    y1_r  <= BUS_DATA;
                    3'd4:    pix_r <= BUS_DATA[0];
                    default: pix_r <= pix_r;
                endcase
            end
            if (state_s == FINISH)                  done_r <= 1'b1;
            else if (wr_s && (offset_s == 3'd4))    done_r <= 1'b0;
        end
    end

    // Fill sequencer, working copies and registered frame-buffer outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            x_r       <= 8'd0;
            y_r       <= 8'd0;
            wx0_r     <= 8'd0;
            wy0_r     <= 8'd0;
            wx1_r     <= 8'd0;
            wy1_r     <= 8'd0;
            wpix_r    <= 1'b0;
            xmin_r    <= 8'd0;
            xmax_r    <= 8'd0;
            ymax_r    <= 8'd0;
            fb_addr_r <= 15'd0;
            fb_data_r <= 1'b0;
            fb_we_r   <= 1'b0;
            busy_r    <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            x_r     <= nx_s;
            y_r     <= ny_s;
            if (start_s) begin
                wx0_r  <= x0_r;
                wy0_r  <= y0_r;
                wx1_r  <= x1_r;
                wy1_r  <= y1_r;
                wpix_r <= BUS_DATA[0];
            end
            if (state_r == SETUP) begin
                xmin_r <= lo_x_s;
                xmax_r <= hi_x_s;
                ymax_r <= hi_y_s;
            end
            fb_addr_r <= {ny_s[6:0], nx_s};
            fb_data_r <= wpix_r;
            fb_we_r   <= (state_s == FILL);
            busy_r    <= (state_s != IDLE);
            irq_r     <= (state_s == FINISH);
        end
    end

    // Read data is presented the cycle after the address is sampled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_oe_r   <= 1'b0;
            rd_data_r <= 8'h00;
        end else begin
            rd_oe_r <= rd_s;
            if (rd_s) rd_data_r <= rd_mux_s;
        end
    end

    assign BUS_DATA   = rd_oe_r ? rd_data_r : 8'hzz;
    assign fb.FB_ADDR = fb_addr_r;
    assign fb.FB_DATA = fb_data_r;
    assign fb.FB_WE   = fb_we_r;
    assign BUSY       = busy_r;
    assign DONE_IRQ   = irq_r;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomized self-checking bench for vga_rect_fill against a raster-order
// reference model of the clipped rectangle.
`timescale 1ns/1ps
module tb_vga_rect_fill;
    localparam logic [7:0] BASE = 8'hB8;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE   = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       drv_en   = 1'b0;
    wire  [7:0] BUS_DATA;
    logic       BUSY, DONE_IRQ;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  rd;

    assign BUS_DATA = drv_en ? drv_data : 8'hzz;

    vga_rect_fill_if fb();

    vga_rect_fill #(.BaseAddr(BASE), .H_PIXELS(160), .V_PIXELS(120)) dut (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(BUS_DATA), .BUS_ADDR(BUS_ADDR),
        .BUS_WE(BUS_WE), .fb(fb), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every pixel of the clipped rectangle, row by row, left to right.
    function automatic void build_expected(input int x0, input int y0, input int x1, input int y1);
        int xlo, xhi, ylo, yhi;
        exp_q.delete();
        xlo = (x0 < x1) ? x0 : x1;
        xhi = (x0 > x1) ? x0 : x1;
        ylo = (y0 < y1) ? y0 : y1;
        yhi = (y0 > y1) ? y0 : y1;
        if (xhi > 159) xhi = 159;
        if (yhi > 119) yhi = 119;
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++)
                exp_q.push_back(15'(y * 256 + x));
    endfunction

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        BUS_ADDR = addr; BUS_WE = 1'b1; drv_data = data; drv_en = 1'b1;
        @(posedge CLK);
        #1;
        BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge CLK);
        BUS_ADDR = addr; BUS_WE = 1'b0;
        @(posedge CLK);
        #1;
        BUS_ADDR = 8'h00;
        @(negedge CLK);
        data = BUS_DATA;
    endtask

    // The bench drives 00 on an idle cycle; any leftover DUT drive would corrupt it.
    task automatic bus_idle_check();
        @(negedge CLK);
        BUS_ADDR = 8'h00; BUS_WE = 1'b1; drv_data = 8'h00; drv_en = 1'b1;
        #1;
        check_eq("bus_released", BUS_DATA, 8'h00);
        @(posedge CLK);
        #1;
        BUS_WE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input bit pix);
        build_expected(x0, y0, x1, y1);
        bus_write(BASE + 8'd0, 8'(x0));
        bus_write(BASE + 8'd1, 8'(y0));
        bus_write(BASE + 8'd2, 8'(x1));
        bus_write(BASE + 8'd3, 8'(y1));
        bus_write(BASE + 8'd4, {6'd0, 1'b1, pix});
    endtask

    task automatic monitor_fill(input bit pix);
        @(negedge CLK);
        check_eq("busy_setup", BUSY, 1'b1);
        check_eq("we_setup", fb.FB_WE, 1'b0);
        foreach (exp_q[i]) begin
            @(negedge CLK);
            check_eq("fb_we", fb.FB_WE, 1'b1);
            check_eq("fb_addr", fb.FB_ADDR, exp_q[i]);
            check_eq("fb_data", fb.FB_DATA, pix);
            check_eq("irq_early", DONE_IRQ, 1'b0);
        end
        @(negedge CLK);
        check_eq("we_finish", fb.FB_WE, 1'b0);
        check_eq("done_irq", DONE_IRQ, 1'b1);
        check_eq("busy_finish", BUSY, 1'b1);
        @(negedge CLK);
        check_eq("irq_single", DONE_IRQ, 1'b0);
        check_eq("busy_drop", BUSY, 1'b0);
    endtask

    task automatic run_fill(input int x0, input int y0, input int x1, input int y1, input bit pix);
        start_fill(x0, y0, x1, y1, pix);
        monitor_fill(pix);
        bus_read(BASE + 8'd5, rd);
        check_eq("status_done", rd, 8'h02);
    endtask

    initial begin
        int x0, y0, x1, y1;
        repeat (3) @(negedge CLK);
        check_eq("rst_fb_we", fb.FB_WE, 1'b0);
        check_eq("rst_fb_addr", fb.FB_ADDR, 15'd0);
        check_eq("rst_fb_data", fb.FB_DATA, 1'b0);
        check_eq("rst_busy", BUSY, 1'b0);
        check_eq("rst_irq", DONE_IRQ, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_read(BASE + 8'(i), rd);
            check_eq("rst_read", rd, 8'h00);
        end

        run_fill(10, 20, 12, 21, 1'b1);
        bus_read(BASE + 8'd0, rd);
        check_eq("x0_readback", rd, 8'd10);
        bus_idle_check();
        bus_read(BASE + 8'd4, rd);
        check_eq("ctrl_readback", rd, 8'h01);
        bus_write(BASE + 8'd5, 8'hFF);
        bus_read(BASE + 8'd5, rd);
        check_eq("status_ro", rd, 8'h02);

        run_fill(5, 0, 3, 0, 1'b0);
        run_fill(158, 119, 200, 130, 1'b1);
        run_fill(170, 10, 170, 12, 1'b1);
        run_fill(7, 7, 7, 7, 1'b1);
        run_fill(255, 255, 255, 255, 1'b0);

        for (int n = 0; n < 20; n++) begin
            x0 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 255);
            x1 = x0 + int'($urandom_range(0, 12)) - 6;
            y1 = y0 + int'($urandom_range(0, 12)) - 6;
            if (x1 < 0) x1 = 0;
            if (x1 > 255) x1 = 255;
            if (y1 < 0) y1 = 0;
            if (y1 > 255) y1 = 255;
            run_fill(x0, y0, x1, y1, 1'($urandom_range(0, 1)));
        end

        // Restart attempt, coordinate rewrite and STATUS read while busy.
        start_fill(20, 30, 29, 33, 1'b1);
        fork
            monitor_fill(1'b1);
            begin
                bus_write(BASE + 8'd4, 8'h02);
                bus_write(BASE + 8'd0, 8'h00);
                bus_read(BASE + 8'd5, rd);
                check_eq("status_busy", rd[0], 1'b1);
            end
        join
        bus_read(BASE + 8'd0, rd);
        check_eq("x0_midfill", rd, 8'h00);
        bus_read(BASE + 8'd4, rd);
        check_eq("ctrl_midfill", rd, 8'h00);
        bus_read(BASE + 8'd5, rd);
        check_eq("status_after", rd, 8'h02);
        bus_write(BASE + 8'd4, 8'h00);
        bus_read(BASE + 8'd5, rd);
        check_eq("status_cleared", rd, 8'h00);

        // Reset in the middle of a 10x10 fill.
        start_fill(0, 0, 9, 9, 1'b1);
        repeat (20) @(negedge CLK);
        check_eq("we_before_rst", fb.FB_WE, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid_we", fb.FB_WE, 1'b0);
        check_eq("rst_mid_busy", BUSY, 1'b0);
        check_eq("rst_mid_irq", DONE_IRQ, 1'b0);
        RESET = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            check_eq("post_rst_irq", DONE_IRQ, 1'b0);
            check_eq("post_rst_we", fb.FB_WE, 1'b0);
        end
        bus_read(BASE + 8'd5, rd);
        check_eq("post_rst_status", rd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Bus-mapped rectangle fill engine that sits directly upstream of the VGA frame buffer's port A.
- The processor programs two corner coordinates and a pixel value, then writes a start bit.
- The engine then streams one frame-buffer write per cycle, in raster order, over the 160x120 one-bit frame buffer.
- Frees the processor from a per-pixel X/Y/data/WE register sequence.

Parameters:
- BaseAddr, 8'hB8, bus address of register 0; the block decodes BaseAddr..BaseAddr+5.
- H_PIXELS, 160, frame width; valid X range is 0..H_PIXELS-1.
- V_PIXELS, 120, frame height; valid Y range is 0..V_PIXELS-1.

Ports:
- CLK  input  1  system clock, 100 MHz
- RESET  input  1  synchronous, active-high reset
- BUS_DATA  inout  8  shared processor data bus; tristated when not driving a read
- BUS_ADDR  input  8  processor bus address
- BUS_WE  input  1  processor bus write enable
- FB_ADDR  output  15  frame-buffer address {Y[6:0], X[7:0]}
- FB_DATA  output  1  pixel value to write
- FB_WE  output  1  frame-buffer write strobe, one pixel per high cycle
- BUSY  output  1  high while a fill is in progress
- DONE_IRQ  output  1  one-cycle pulse on completion of a fill

Behaviour:
- Registers (offset from BaseAddr):
  - 0 X0, 1 Y0, 2 X1, 3 Y1: R/W.
  - 4 CTRL: bit0 = pixel value (R/W); bit1 = START (write-only, self-clearing, reads 0).
  - 5 STATUS: read-only; bit0 = BUSY, bit1 = DONE (sticky; cleared by any write to CTRL).
- Bus writes to offset 5 are ignored.
- Bus reads: when an address is in range and BUS_WE=0, BUS_DATA is driven on the following cycle with the register value sampled on that edge. Otherwise BUS_DATA is 8'hZZ.
- Bus writes take effect on the edge where BUS_WE=1 and the address is in range.
- Reset values: all registers 0, FB_ADDR 0, FB_DATA 0, FB_WE 0, BUSY 0, DONE_IRQ 0, bus released, FSM in IDLE.
- FSM states: IDLE, SETUP, FILL, FINISH.
- IDLE -> SETUP on an accepted START write (CTRL bit1=1). At that edge, X0/Y0/X1/Y1 and the pixel value are latched into working copies.
  - Later bus writes to the coordinate registers do not affect the running fill.
- SETUP (1 cycle):
  - xmin = min(X0,X1), xmax = min(max(X0,X1), H_PIXELS-1); ymin/ymax likewise with V_PIXELS-1.
  - If xmin > H_PIXELS-1 or ymin > V_PIXELS-1, the rectangle is empty: go to FINISH with no writes.
  - Otherwise load x=xmin, y=ymin and go to FILL.
- FILL:
  - Each cycle, FB_WE=1, FB_ADDR={y[6:0],x[7:0]}, FB_DATA = latched pixel value (registered outputs).
  - If x==xmax: x=xmin and y=y+1; otherwise x=x+1.
  - After the pixel (xmax,ymax) is issued, go to FINISH.
- FINISH (1 cycle): FB_WE=0, DONE_IRQ=1 for this cycle, STATUS.DONE set, then return to IDLE.
- Latency: the START write is sampled at edge N. BUSY is high from cycle N+1. The first FB_WE is high in cycle N+2.
- A fill of W x H pixels gives exactly W*H consecutive FB_WE cycles, followed by the DONE_IRQ pulse in the next cycle.
- BUSY stays high through SETUP, FILL and FINISH, and drops the cycle after FINISH.
- START while BUSY is ignored: no restart and no state change. Writes to CTRL bit0 while BUSY update the register only, not the running fill.
- If a CTRL write clears DONE on the same edge as FINISH sets it, the set wins.
- RESET mid-fill: on the next edge FB_WE=0, FSM goes to IDLE, BUSY=0, DONE is not set, no DONE_IRQ.
- X0==X1 and Y0==Y1 gives a single pixel write.
- Coordinates up to 255 are accepted. Values beyond the frame are clipped as above, never wrapped.

Test Plan:
- Reset, then read offsets 0-5 -> every read returns 8'h00. BUS_DATA is high-Z in cycles with no read.
- X0=10, Y0=20, X1=12, Y1=21, CTRL=8'h03 -> 6 FB_WE cycles starting 2 cycles after the write edge. Addresses are {20,10},{20,11},{20,12},{21,10},{21,11},{21,12}, FB_DATA=1. Then one DONE_IRQ pulse; STATUS reads 8'h02.
- Swapped corners X0=5, X1=3, Y0=Y1=0, CTRL=8'h02 -> 3 writes at X=3,4,5, Y=0, FB_DATA=0.
- Clipping: X0=158, X1=200, Y0=119, Y1=130 -> 2 writes, at (158,119) and (159,119). X0=X1=170 -> no writes, DONE_IRQ 2 cycles after start.
- START again mid-fill, plus a write X0=0 mid-fill -> original fill completes unchanged with a single DONE_IRQ. Assert RESET during a 100-pixel fill -> FB_WE low on the next cycle, no DONE_IRQ, BUSY=0.
- Read STATUS during a fill -> bit0=1. After completion, write CTRL=8'h00 -> STATUS reads 8'h00.
